// File: rtl/voter_pkg.sv
// ----------------------------------------------------------------------------
// voter_pkg
//   Shared types and helpers for the parametrised ballot controller.
//   - voter_state_t : controller FSM states
//   - VOTER_MAX     : largest supported number of voters
//   - cnt_w(n)      : bits needed to hold a count in 0..n
// ----------------------------------------------------------------------------
package voter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        RX      = 3'd2,
        CHECK   = 3'd3,
        SEND    = 3'd4,
        RELEASE = 3'd5
    } voter_state_t;

    localparam int VOTER_MAX = 32;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/param_voter_ctrl_popcount.sv
// ----------------------------------------------------------------------------
// voter_popcount
//   Combinational ones-count of a vote vector, built as a ripple of partial
//   sums so it scales with N without a hand-written adder tree.
//   Ports:
//     votes_i : N-bit vote vector
//     ones_o  : number of set bits, cnt_w(N) bits wide
// ----------------------------------------------------------------------------
module voter_popcount
    import voter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        votes_i,
    output logic [cnt_w(N)-1:0] ones_o
);

    localparam int CW = cnt_w(N);

    logic [CW-1:0] partial [0:N];

    assign partial[0] = '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_sum
        assign partial[gi+1] = partial[gi] + {{(CW-1){1'b0}}, votes_i[gi]};
    end

    assign ones_o = partial[N];

endmodule

// File: rtl/param_voter_ctrl.sv
// ----------------------------------------------------------------------------
// param_voter_ctrl
//   Ballot controller for N_VOTERS voters. Votes arrive either one at a time
//   from edge-detected red/green buttons or as a parallel word over the
//   rts/ctr handshake. Once closed with key, the majority and tie flags are
//   computed and the ballot is offered downstream over the cts/rtr 4-phase
//   handshake.
//
//   Optional feature macro: VOTER_TIMEOUT_EN
//     Defined   : RX/SEND/RELEASE abandon the ballot after TIMEOUT_CYC cycles
//                 without the awaited handshake edge, pulsing err_o.
//     Undefined : handshakes wait forever, err_o is tied low.
//
//   Ports:
//     clock_i    : system clock, rising edge
//     reset_i    : asynchronous active-high reset
//     start_i    : opens a ballot from IDLE
//     test_i     : sampled with start_i; 1 = test ballot (all ones)
//     r_button_i : red vote (0), rising edge counts
//     g_button_i : green vote (1), rising edge counts
//     key_i      : closes the ballot once every voter has voted
//     rts_i      : upstream request to send parallel votes
//     v_in_i     : parallel votes, valid while rts_i=1
//     ctr_o      : clear-to-receive acknowledge to upstream
//     rtr_i      : downstream ready-to-receive
//     cts_o      : clear-to-send; v_out_o valid while high
//     v_out_o    : ballot, bit i = voter i
//     result_o   : majority of ones
//     tie_o      : exactly half ones (even N only)
//     busy_o     : controller not in IDLE
//     err_o      : one-cycle handshake timeout pulse
// ----------------------------------------------------------------------------
module param_voter_ctrl
    import voter_pkg::*;
#(
    parameter int N_VOTERS    = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                test_i,
    input  logic                r_button_i,
    input  logic                g_button_i,
    input  logic                key_i,
    input  logic                rts_i,
    input  logic [N_VOTERS-1:0] v_in_i,
    output logic                ctr_o,
    input  logic                rtr_i,
    output logic                cts_o,
    output logic [N_VOTERS-1:0] v_out_o,
    output logic                result_o,
    output logic                tie_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int            CW     = cnt_w(N_VOTERS);
    localparam logic [CW-1:0] N_CNT  = CW'(N_VOTERS);
    localparam logic [CW-1:0] HALF   = CW'(N_VOTERS / 2);
    localparam bit            EVEN_N = (N_VOTERS % 2) == 0;

    if (N_VOTERS < 2 || N_VOTERS > VOTER_MAX || TIMEOUT_CYC < 1) begin : g_param_check
        $error("param_voter_ctrl: N_VOTERS must be 2..32 and TIMEOUT_CYC >= 1");
    end

    voter_state_t        state_q;
    logic [N_VOTERS-1:0] votes_q;
    logic [CW-1:0]       idx_q;
    logic                last_r_q;
    logic                last_g_q;
    logic                ctr_q;
    logic                cts_q;
    logic [N_VOTERS-1:0] v_out_q;
    logic                result_q;
    logic                tie_q;

    logic                r_edge;
    logic                g_edge;
    logic                rec_en;
    logic [N_VOTERS-1:0] idx_sel;
    logic [N_VOTERS-1:0] votes_rec;
    logic [CW-1:0]       ones;
    logic                tmo_hit;

    assign r_edge = r_button_i & ~last_r_q;
    assign g_edge = g_button_i & ~last_g_q;

    // Exactly one button edge records a vote; both at once is ambiguous.
    assign rec_en = (r_edge ^ g_edge) && (idx_q < N_CNT);

    // One-hot select of the current voter avoids indexing the vote vector
    // with a counter that is one bit wider than the index range.
    for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_idx_sel
        assign idx_sel[gi] = (idx_q == CW'(gi));
    end

    assign votes_rec = (votes_q & ~idx_sel) | (idx_sel & {N_VOTERS{g_edge}});

    voter_popcount #(
        .N (N_VOTERS)
    ) u_popcount (
        .votes_i (votes_q),
        .ones_o  (ones)
    );

`ifdef VOTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    // The counter restarts at 0 on every state entry; the hit fires on the
    // TIMEOUT_CYC-th cycle spent waiting in the same state.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign err_o   = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            votes_q  <= '0;
            idx_q    <= '0;
            last_r_q <= 1'b0;
            last_g_q <= 1'b0;
            ctr_q    <= 1'b0;
            cts_q    <= 1'b0;
            v_out_q  <= '0;
            result_q <= 1'b0;
            tie_q    <= 1'b0;
`ifdef VOTER_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // Edge history tracks the buttons in every state so that a
            // button held across a state change does not count twice.
            last_r_q <= r_button_i;
            last_g_q <= g_button_i;
`ifdef VOTER_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        v_out_q  <= '0;
                        result_q <= 1'b0;
                        tie_q    <= 1'b0;
                        if (test_i) begin
                            votes_q <= '1;
                            idx_q   <= N_CNT;
                            state_q <= CHECK;
                        end else begin
                            votes_q <= '0;
                            idx_q   <= '0;
                            state_q <= COLLECT;
                        end
                    end
                end

                COLLECT: begin
                    if (rts_i) begin
                        ctr_q   <= 1'b1;
                        state_q <= RX;
                    end else if (rec_en) begin
                        votes_q <= votes_rec;
                        idx_q   <= idx_q + CW'(1);
                    end else if (key_i && (idx_q == N_CNT)) begin
                        state_q <= CHECK;
                    end
                end

                RX: begin
                    if (!rts_i) begin
                        ctr_q   <= 1'b0;
                        idx_q   <= N_CNT;
                        state_q <= COLLECT;
                    end else if (tmo_hit) begin
                        ctr_q   <= 1'b0;
                        votes_q <= '0;
                        idx_q   <= '0;
                        state_q <= IDLE;
`ifdef VOTER_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end else begin
                        votes_q <= v_in_i;
`ifdef VOTER_TIMEOUT_EN
                        tmo_q   <= tmo_q + TW'(1);
`endif
                    end
                end

                CHECK: begin
                    result_q <= (ones > HALF);
                    tie_q    <= EVEN_N && (ones == HALF);
                    cts_q    <= 1'b1;
                    v_out_q  <= votes_q;
                    state_q  <= SEND;
                end

                SEND: begin
                    if (rtr_i) begin
                        cts_q   <= 1'b0;
                        state_q <= RELEASE;
                    end else if (tmo_hit) begin
                        cts_q   <= 1'b0;
                        votes_q <= '0;
                        idx_q   <= '0;
                        state_q <= IDLE;
`ifdef VOTER_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end else begin
`ifdef VOTER_TIMEOUT_EN
                        tmo_q   <= tmo_q + TW'(1);
`endif
                    end
                end

                RELEASE: begin
                    if (!rtr_i) begin
                        state_q <= IDLE;
                    end else if (tmo_hit) begin
                        votes_q <= '0;
                        idx_q   <= '0;
                        state_q <= IDLE;
`ifdef VOTER_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end else begin
`ifdef VOTER_TIMEOUT_EN
                        tmo_q   <= tmo_q + TW'(1);
`endif
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ctr_o    = ctr_q;
    assign cts_o    = cts_q;
    assign v_out_o  = v_out_q;
    assign result_o = result_q;
    assign tie_o    = tie_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_param_voter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_param_voter_ctrl
//   Directed bench for param_voter_ctrl with N_VOTERS=4. Expected ballots are
//   queued when a ballot is closed and compared when cts rises.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_voter_ctrl;

    localparam int N = 4;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         start_i = 1'b0;
    logic         test_i = 1'b0;
    logic         r_button_i = 1'b0;
    logic         g_button_i = 1'b0;
    logic         key_i = 1'b0;
    logic         rts_i = 1'b0;
    logic [N-1:0] v_in_i = '0;
    logic         ctr_o;
    logic         rtr_i = 1'b0;
    logic         cts_o;
    logic [N-1:0] v_out_o;
    logic         result_o;
    logic         tie_o;
    logic         busy_o;
    logic         err_o;

    param_voter_ctrl #(
        .N_VOTERS    (N),
        .TIMEOUT_CYC (8)
    ) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .test_i     (test_i),
        .r_button_i (r_button_i),
        .g_button_i (g_button_i),
        .key_i      (key_i),
        .rts_i      (rts_i),
        .v_in_i     (v_in_i),
        .ctr_o      (ctr_o),
        .rtr_i      (rtr_i),
        .cts_o      (cts_o),
        .v_out_o    (v_out_o),
        .result_o   (result_o),
        .tie_o      (tie_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [N-1:0] v;
        logic         r;
        logic         t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    // Majority/tie derived directly from the ballot bits.
    task automatic push_exp(input logic [N-1:0] v);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(v[i]);
        e.v = v;
        e.r = (ones * 2 > N);
        e.t = (ones * 2 == N);
        sb.push_back(e);
        $display("queue ballot v=%b result=%0d tie=%0d", e.v, e.r, e.t);
    endtask

    task automatic press(input logic green);
        if (green) g_button_i = 1'b1; else r_button_i = 1'b1;
        tick();
        g_button_i = 1'b0;
        r_button_i = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic test);
        start_i = 1'b1;
        test_i  = test;
        tick();
        start_i = 1'b0;
        test_i  = 1'b0;
    endtask

    task automatic close_ballot();
        key_i = 1'b1;
        tick();
        key_i = 1'b0;
    endtask

    task automatic wait_cts(input string tag);
        int n;
        n = 0;
        while (cts_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_cts_rise"}, 32'(cts_o), 32'd1);
    endtask

    // Compare the presented ballot against the scoreboard head.
    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_v_out"}, 32'(v_out_o), 32'(e.v));
            check({tag, "_result"}, 32'(result_o), 32'(e.r));
            check({tag, "_tie"}, 32'(tie_o), 32'(e.t));
            $display("ballot %s v_out=%b result=%0d tie=%0d", tag, v_out_o, result_o, tie_o);
        end
    endtask

    task automatic receive_ballot(input string tag);
        wait_cts(tag);
        compare_head(tag);
        rtr_i = 1'b1;
        tick();
        check({tag, "_cts_drop"}, 32'(cts_o), 32'd0);
        check({tag, "_busy_rel"}, 32'(busy_o), 32'd1);
        rtr_i = 1'b0;
        tick();
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        // Reset state
        reset_i = 1'b1;
        tick(2);
        check("rst_ctr", 32'(ctr_o), 32'd0);
        check("rst_cts", 32'(cts_o), 32'd0);
        check("rst_v_out", 32'(v_out_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_tie", 32'(tie_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // 1) g,r,g,g -> 1101, majority
        do_start(1'b0);
        check("t1_busy", 32'(busy_o), 32'd1);
        press(1'b1); press(1'b0); press(1'b1); press(1'b1);
        push_exp(4'b1101);
        close_ballot();
        receive_ballot("t1");

        // 2) g,g,r,r -> 0011, tie
        do_start(1'b0);
        press(1'b1); press(1'b1); press(1'b0); press(1'b0);
        push_exp(4'b0011);
        close_ballot();
        receive_ballot("t2");

        // 3) parallel transfer
        do_start(1'b0);
        rts_i  = 1'b1;
        v_in_i = 4'b0011;
        tick();
        check("t3_ctr_high", 32'(ctr_o), 32'd1);
        tick();
        rts_i  = 1'b0;
        v_in_i = 4'b1111;
        tick();
        check("t3_ctr_low", 32'(ctr_o), 32'd0);
        push_exp(4'b0011);
        close_ballot();
        receive_ballot("t3");

        // 4) simultaneous edges ignored, held button counts once, early key ignored
        do_start(1'b0);
        press(1'b1);
        r_button_i = 1'b1;
        g_button_i = 1'b1;
        tick();
        r_button_i = 1'b0;
        g_button_i = 1'b0;
        tick();
        r_button_i = 1'b1;
        tick(4);
        r_button_i = 1'b0;
        tick();
        press(1'b1);
        close_ballot();
        tick(3);
        check("t4_early_key_cts", 32'(cts_o), 32'd0);
        check("t4_early_key_busy", 32'(busy_o), 32'd1);
        press(1'b0);
        push_exp(4'b0101);
        close_ballot();
        receive_ballot("t4");

        // 5) reset mid-SEND, then a test ballot
        do_start(1'b0);
        press(1'b1); press(1'b1); press(1'b1); press(1'b1);
        push_exp(4'b1111);
        close_ballot();
        wait_cts("t5a");
        compare_head("t5a");
        reset_i = 1'b1;
        #1;
        check("t5_rst_cts", 32'(cts_o), 32'd0);
        check("t5_rst_v_out", 32'(v_out_o), 32'd0);
        check("t5_rst_busy", 32'(busy_o), 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        check("t5_idle_after", 32'(busy_o), 32'd0);
        do_start(1'b1);
        push_exp(4'b1111);
        receive_ballot("t5b");

        // 6) downstream never acknowledges
        do_start(1'b1);
        push_exp(4'b1111);
        wait_cts("t6");
        compare_head("t6");
`ifdef VOTER_TIMEOUT_EN
        tick(8);
        check("t6_err_pulse", 32'(err_o), 32'd1);
        check("t6_cts_drop", 32'(cts_o), 32'd0);
        check("t6_idle", 32'(busy_o), 32'd0);
        tick();
        check("t6_err_one_cycle", 32'(err_o), 32'd0);
`else
        tick(40);
        check("t6_cts_held", 32'(cts_o), 32'd1);
        check("t6_busy_held", 32'(busy_o), 32'd1);
        check("t6_no_err", 32'(err_o), 32'd0);
        rtr_i = 1'b1;
        tick();
        rtr_i = 1'b0;
        tick();
        check("t6_idle", 32'(busy_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
